xgmii_udp_tx_engine: RTL and testbench
======================================

# xgmii_udp_tx_engine

Parametrised XGMII frame generator that wraps FIFO payload words into Ethernet/IPv4/UDP frames and drives a 72-bit XGMII TX bus (8 control bits plus 64 data bits). It sits between the PCIe-side TX FIFO and the 10G PHY.

Compared with the fixed-format engine it replaces, it adds:

- runtime payload length;
- incrementing IPv4 ID;
- fully folded header checksum;
- zero-fill on FIFO underrun;
- a programmable inter-frame gap;
- frame and underrun statistics.

## Interface
Parameters:
- MAX_PAYLOAD_WORDS, 32: upper clamp on payload words per frame (8 bytes each).
- IFG_CYCLES, 1: idle XGMII words emitted after each terminate word. Must be ≥1.
- IPV4_TTL, 8'h40: TTL field.
- UDP_SRC_PORT, 16'h0009; UDP_DST_PORT, 16'h0009: UDP source and destination ports.
- MAGIC_CODE, 32'h0: 4-byte tag placed ahead of the payload.

Ports:
- xgmii_clk  in  1  the only clock.
- sys_rst  in  1  reset; synchronous, active-high.
- tx_enable  in  1  allows a new frame to start.
- payload_words  in  8  payload words per frame. Clamped to [2, MAX_PAYLOAD_WORDS].
- fifo_dout  in  72  FWFT FIFO word: [71:64] byte-valid mask, [63:0] data (byte 0 = [7:0]).
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pops the word currently on fifo_dout.
- if_v4addr  in  32  source IPv4 address.
- if_macaddr  in  48  source MAC.
- dest_v4addr  in  32  destination IPv4 address.
- dest_macaddr  in  48  destination MAC.
- xgmii_txd  out  72  {txc[7:0], txd[63:0]}. Registered.
- busy  out  1  high from the start decision through the last gap word.
- frame_count  out  32  frames completed. Wraps.
- underrun_count  out  16  zero-filled payload words. Saturates at 16'hFFFF.

## Operation
- States: IDLE → PREAMBLE → HEADER (6 words) → PAYLOAD (N words) → TERM → GAP (IFG_CYCLES words) → IDLE.
- Start condition: IDLE with tx_enable=1 and fifo_empty=0.
  - On start, latch N (clamped), all four address inputs and the current ipv4_id.
  - Address changes during a frame do not affect that frame.
- PREAMBLE word: txc=8'h01, txd=64'hd5555555555555fb.
- HEADER: txc=0. The words carry, in byte order:
  - dest MAC, src MAC;
  - 0x0800, 0x45, 0x00;
  - ip_len = 34+8N, id, flags/frag 0, TTL, protocol 0x11;
  - checksum, src IP, dst IP;
  - UDP src port, UDP dst port, udp_len = 14+8N, UDP checksum 0x0000;
  - MAGIC_CODE, 16'h0000.
  - All multi-byte fields are big-endian on the wire.
- IPv4 checksum:
  - 32-bit one's-complement sum of the ten header halfwords.
  - Fold the carry twice, then invert.
  - Computed during PREAMBLE; valid before header word 3.
- PAYLOAD, word k:
  - If fifo_empty=0: transmit fifo_dout[63:0] with txc=0, and pulse fifo_rd_en=1 in that cycle. Bytes whose mask bit is 0 are sent as 8'h00.
  - If fifo_empty=1 (underrun): transmit 64'h0 with fifo_rd_en=0 and increment underrun_count. The frame still completes with N words.
- TERM word: txc=8'hf0, txd={24'h070707, 8'hfd, FCS}.
  - FCS is Ethernet CRC32 over dest MAC through the last payload byte, least significant byte first.
  - Computed with crc32_d64.
- GAP: txc=8'hff, txd=64'h0707070707070707.
- At TERM: frame_count += 1 and ipv4_id += 1 (mod 2^16).
- tx_enable deasserted mid-frame does not abort the frame; it only blocks the next start.

## Timing
- Reset values (cycle after sys_rst sampled high):
  - xgmii_txd = {8'hff, 64'h0707070707070707};
  - fifo_rd_en = 0, busy = 0;
  - frame_count = 0, underrun_count = 0;
  - ipv4_id = 0; state IDLE.
- Reset mid-frame: idle words from the next cycle; no TERM is emitted. Counters clear.
- Start latency: the preamble appears on xgmii_txd in the cycle after the start condition is sampled. busy rises in the same cycle.
- Frame length on the bus: 1+6+N+1 words, then IFG_CYCLES gap words, then at least 1 IDLE word before the next preamble.
- fifo_rd_en for payload word k is asserted in the cycle that word is registered into xgmii_txd. It is never asserted outside PAYLOAD and never while fifo_empty=1.
- Simultaneous fifo_empty falling and the last payload cycle: the word is consumed normally.
- N changes mid-frame are ignored.

## Test plan
- Reset, then N=2, empty=0, MACs/IPs fixed → preamble, 6 header words, 2 payload words, then TERM. Check: ip_len=50, udp_len=30, checksum matches the software model, FCS matches the software CRC, 1 gap word, frame_count=1.
- Three back-to-back frames, N=4, IFG_CYCLES=3 → IDs 0, 1, 2 with checksums differing accordingly. Exactly 3 gap words plus 1 IDLE word between frames; fifo_rd_en pulse count = 12.
- N=4 with the FIFO emptying after 2 words → payload words 3 and 4 are all zeros, underrun_count=2, TERM still present with a correct FCS.
- payload_words=0 and payload_words=255 with MAX_PAYLOAD_WORDS=32 → frames of 2 and 32 payload words respectively.
- sys_rst asserted during payload word 2 → idle words on the next cycle, busy=0, counters 0. A new frame starts with ID 0.
- tx_enable=0 with the FIFO non-empty → bus stays idle and fifo_rd_en stays 0. Raising tx_enable → preamble on the next cycle.

Source files
------------

// File: rtl/xgmii_udp_tx_engine_if.sv
// Bus bundle between the TX FIFO / control side and the XGMII UDP frame engine.
interface xgmii_udp_tx_engine_if;
    logic        tx_enable;
    logic [7:0]  payload_words;
    logic [71:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] if_v4addr;
    logic [47:0] if_macaddr;
    logic [31:0] dest_v4addr;
    logic [47:0] dest_macaddr;
    logic [71:0] xgmii_txd;
    logic        busy;
    logic [31:0] frame_count;
    logic [15:0] underrun_count;

    modport master (
        output tx_enable, payload_words, fifo_dout, fifo_empty,
               if_v4addr, if_macaddr, dest_v4addr, dest_macaddr,
        input  fifo_rd_en, xgmii_txd, busy, frame_count, underrun_count
    );

    modport slave (
        input  tx_enable, payload_words, fifo_dout, fifo_empty,
               if_v4addr, if_macaddr, dest_v4addr, dest_macaddr,
        output fifo_rd_en, xgmii_txd, busy, frame_count, underrun_count
    );
endinterface

// File: rtl/xgmii_udp_tx_engine.sv
// XGMII Ethernet/IPv4/UDP frame generator fed from a FWFT payload FIFO.
//
// state      | meaning (word currently on xgmii_txd)
// S_IDLE     | idle word, waiting for tx_enable with FIFO data
// S_PREAMBLE | start/preamble word; header checksum being computed
// S_HEADER   | one of the six header words (cnt = words still to send)
// S_PAYLOAD  | payload word (cnt = payload words still to send)
// S_TERM     | terminate word carrying the FCS
// S_GAP      | inter-frame idle words (cnt = gap words still to send)
module xgmii_udp_tx_engine #(
    parameter int          MAX_PAYLOAD_WORDS = 32,
    parameter int          IFG_CYCLES        = 1,
    parameter logic [7:0]  IPV4_TTL          = 8'h40,
    parameter logic [15:0] UDP_SRC_PORT      = 16'h0009,
    parameter logic [15:0] UDP_DST_PORT      = 16'h0009,
    parameter logic [31:0] MAGIC_CODE        = 32'h0
) (
    input logic                  xgmii_clk,
    input logic                  sys_rst,
    xgmii_udp_tx_engine_if.slave bus
);
    localparam logic [71:0] IDLE_WORD = {8'hff, 64'h0707070707070707};
    localparam logic [71:0] PRE_WORD  = {8'h01, 64'hd5555555555555fb};
    localparam logic [7:0]  MAX_N     = 8'(MAX_PAYLOAD_WORDS);
    localparam logic [7:0]  GAP_LOAD  = 8'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TERM, S_GAP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt, n_lat, n_clamp;
    logic [47:0] dmac_lat, smac_lat;
    logic [31:0] sip_lat, dip_lat, crc, csum_sum, frame_cnt;
    logic [15:0] ipv4_id, id_lat, csum, ip_len, udp_len, underrun_cnt;
    logic [71:0] txd_q, txd_nxt;
    logic [383:0] hdr_be;
    logic [63:0] hdr_w [0:7];
    logic [63:0] pay_word;
    logic [2:0]  hdr_idx;
    logic        start, pay_load, term_load;

    // Bit-serial reflected CRC32 over one 64-bit word, byte 0 first, LSB first.
    function automatic logic [31:0] crc32_d64(input logic [31:0] crc_in, input logic [63:0] d);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 64; i++)
            c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
        return c;
    endfunction

    function automatic logic [15:0] fold_csum(input logic [31:0] s);
        logic [31:0] t;
        t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
        return ~t[15:0];
    endfunction

    assign n_clamp  = (bus.payload_words < 8'd2) ? 8'd2 :
                      (bus.payload_words > MAX_N) ? MAX_N : bus.payload_words;
    assign ip_len   = 16'd34 + {5'd0, n_lat, 3'd0};
    assign udp_len  = 16'd14 + {5'd0, n_lat, 3'd0};
    assign csum_sum = 32'h0000_4500 + {16'h0, ip_len} + {16'h0, id_lat} + {16'h0, IPV4_TTL, 8'h11}
                    + {16'h0, sip_lat[31:16]} + {16'h0, sip_lat[15:0]}
                    + {16'h0, dip_lat[31:16]} + {16'h0, dip_lat[15:0]};
    // Header laid out in wire order, first byte in the top bits.
    assign hdr_be   = {dmac_lat, smac_lat, 16'h0800, 8'h45, 8'h00, ip_len, id_lat, 16'h0000,
                       IPV4_TTL, 8'h11, csum, sip_lat, dip_lat, UDP_SRC_PORT, UDP_DST_PORT,
                       udp_len, 16'h0000, MAGIC_CODE, 16'h0000};
    assign hdr_idx  = 3'(8'd6 - cnt);

    // Slice the wire-order header into XGMII words, byte 0 in bits [7:0].
    always_comb begin
        for (int w = 0; w < 8; w++) hdr_w[w] = '0;
        for (int w = 0; w < 6; w++)
            for (int b = 0; b < 8; b++)
                hdr_w[w][8*b +: 8] = hdr_be[383 - 8*(8*w + b) -: 8];
    end

    // Payload word with invalid bytes zeroed; all zeros on underrun.
    always_comb begin
        pay_word = '0;
        for (int b = 0; b < 8; b++)
            if (!bus.fifo_empty && bus.fifo_dout[64 + b]) pay_word[8*b +: 8] = bus.fifo_dout[8*b +: 8];
    end

    // FSM state register.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and the word to register onto the bus next.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        txd_nxt   = IDLE_WORD;
        start     = 1'b0;
        pay_load  = 1'b0;
        term_load = 1'b0;
        case (state)
            S_IDLE: if (bus.tx_enable && !bus.fifo_empty) begin
                start     = 1'b1;
                state_nxt = S_PREAMBLE;
                txd_nxt   = PRE_WORD;
            end
            S_PREAMBLE: begin
                state_nxt = S_HEADER;
                cnt_nxt   = 8'd5;
                txd_nxt   = {8'h00, hdr_w[0]};
            end
            S_HEADER: if (cnt != 8'd0) begin
                cnt_nxt = cnt - 8'd1;
                txd_nxt = {8'h00, hdr_w[hdr_idx]};
            end else begin
                state_nxt = S_PAYLOAD;
                cnt_nxt   = n_lat - 8'd1;
                pay_load  = 1'b1;
                txd_nxt   = {8'h00, pay_word};
            end
            S_PAYLOAD: if (cnt != 8'd0) begin
                cnt_nxt  = cnt - 8'd1;
                pay_load = 1'b1;
                txd_nxt  = {8'h00, pay_word};
            end else begin
                state_nxt = S_TERM;
                term_load = 1'b1;
                txd_nxt   = {8'hf0, 24'h070707, 8'hfd, ~crc};
            end
            S_TERM: begin
                state_nxt = S_GAP;
                cnt_nxt   = GAP_LOAD;
            end
            S_GAP: if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
                   else state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register, per-frame latches, CRC/checksum and statistics.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            txd_q        <= IDLE_WORD;
            n_lat        <= 8'd2;
            dmac_lat     <= '0;
            smac_lat     <= '0;
            sip_lat      <= '0;
            dip_lat      <= '0;
            id_lat       <= '0;
            ipv4_id      <= '0;
            csum         <= '0;
            crc          <= '1;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            txd_q <= txd_nxt;
            if (start) begin
                n_lat    <= n_clamp;
                dmac_lat <= bus.dest_macaddr;
                smac_lat <= bus.if_macaddr;
                sip_lat  <= bus.if_v4addr;
                dip_lat  <= bus.dest_v4addr;
                id_lat   <= ipv4_id;
                crc      <= '1;
            end
            if (state == S_PREAMBLE) csum <= fold_csum(csum_sum);
            if (state_nxt == S_HEADER || pay_load) crc <= crc32_d64(crc, txd_nxt[63:0]);
            if (term_load) begin
                frame_cnt <= frame_cnt + 32'd1;
                ipv4_id   <= ipv4_id + 16'd1;
            end
            if (pay_load && bus.fifo_empty && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    assign bus.fifo_rd_en     = pay_load && !bus.fifo_empty && !sys_rst;
    assign bus.xgmii_txd      = txd_q;
    assign bus.busy           = (state != S_IDLE);
    assign bus.frame_count    = frame_cnt;
    assign bus.underrun_count = underrun_cnt;
endmodule

// File: tb/tb_xgmii_udp_tx_engine.sv
// Self-checking bench for xgmii_udp_tx_engine: a byte-level frame model built
// from the frame layout, a FWFT FIFO model, and per-scenario tasks.
module tb_xgmii_udp_tx_engine;
    localparam int          MAXW  = 32;
    localparam int          IFG   = 3;
    localparam logic [7:0]  TTL   = 8'h40;
    localparam logic [15:0] SPORT = 16'h1234;
    localparam logic [15:0] DPORT = 16'h5678;
    localparam logic [31:0] MAGIC = 32'hCAFEF00D;
    localparam logic [71:0] IDLEW = {8'hff, 64'h0707070707070707};
    localparam logic [71:0] PRE   = {8'h01, 64'hd5555555555555fb};

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    xgmii_udp_tx_engine_if bus();

    xgmii_udp_tx_engine #(
        .MAX_PAYLOAD_WORDS(MAXW), .IFG_CYCLES(IFG), .IPV4_TTL(TTL),
        .UDP_SRC_PORT(SPORT), .UDP_DST_PORT(DPORT), .MAGIC_CODE(MAGIC)
    ) dut (
        .xgmii_clk(clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    // FWFT FIFO model
    logic [71:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_pulses = 0;
    int rd_viol = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (sys_rst) rd_ptr <= wr_ptr;
        else if (bus.fifo_rd_en) begin
            rd_ptr    <= rd_ptr + 1;
            rd_pulses <= rd_pulses + 1;
        end
        if (bus.fifo_rd_en && bus.fifo_empty) rd_viol <= rd_viol + 1;
    end

    int checks = 0;
    int fails = 0;
    int m_frames = 0;
    int m_under = 0;
    logic [15:0] m_id = 16'h0;
    logic [71:0] mq[$];
    logic [7:0]  fb[$];

    task automatic push_word();
        logic [71:0] w;
        w[63:0]  = {$urandom, $urandom};
        w[71:64] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        mq.push_back(w);
    endtask

    task automatic rand_addr();
        bus.if_macaddr   = {16'($urandom), $urandom};
        bus.dest_macaddr = {16'($urandom), $urandom};
        bus.if_v4addr    = $urandom;
        bus.dest_v4addr  = $urandom;
    endtask

    function automatic void push_be(input logic [63:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
    endfunction

    function automatic logic [31:0] eth_fcs(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i])
            for (int j = 0; j < 8; j++)
                if (c[0] ^ q[i][j]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
        return ~c;
    endfunction

    // Waits for a preamble, then checks the whole frame, gap and trailing idle.
    task automatic check_frame(input string tag, input bit scramble, input int max_wait);
        int waited, n;
        logic [7:0]  pw_save;
        logic [47:0] dm, sm;
        logic [31:0] si, di, sum, fcs;
        logic [15:0] ck;
        logic [71:0] w, expw;
        logic [63:0] exp64;
        waited = 0;
        while (bus.xgmii_txd !== PRE && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.xgmii_txd !== PRE) begin
            fails++;
            $display("FAIL %s preamble: txd=%h expected %h after %0d cycles", tag, bus.xgmii_txd, PRE, waited);
            return;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_at_preamble: got %b expected 1", tag, bus.busy);
        end
        dm = bus.dest_macaddr; sm = bus.if_macaddr; si = bus.if_v4addr; di = bus.dest_v4addr;
        pw_save = bus.payload_words;
        n = (pw_save < 2) ? 2 : (pw_save > MAXW) ? MAXW : int'(pw_save);
        if (scramble) begin
            rand_addr();
            bus.payload_words = 8'($urandom);
        end
        fb.delete();
        push_be(dm, 6); push_be(sm, 6); push_be(64'h0800, 2); push_be(64'h45, 1); push_be(0, 1);
        push_be(64'(34 + 8*n), 2); push_be(64'(m_id), 2); push_be(0, 2); push_be(64'(TTL), 1);
        push_be(64'h11, 1); push_be(0, 2); push_be(64'(si), 4); push_be(64'(di), 4);
        push_be(64'(SPORT), 2); push_be(64'(DPORT), 2); push_be(64'(14 + 8*n), 2); push_be(0, 2);
        push_be(64'(MAGIC), 4); push_be(0, 2);
        sum = 32'h0;
        for (int i = 14; i < 34; i += 2) sum += {16'h0, fb[i], fb[i+1]};
        sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        ck = ~sum[15:0];
        fb[24] = ck[15:8];
        fb[25] = ck[7:0];
        for (int k = 0; k < n; k++) begin
            if (mq.size() > 0) begin
                w = mq.pop_front();
                for (int b = 0; b < 8; b++) fb.push_back(w[64 + b] ? w[8*b +: 8] : 8'h00);
            end else begin
                for (int b = 0; b < 8; b++) fb.push_back(8'h00);
                m_under++;
            end
        end
        fcs = eth_fcs(fb);
        for (int wi = 0; wi < 6 + n; wi++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) exp64[8*b +: 8] = fb[8*wi + b];
            expw = {8'h00, exp64};
            checks++;
            if (bus.xgmii_txd !== expw) begin
                fails++;
                $display("FAIL %s word%0d: txd=%h expected %h", tag, wi, bus.xgmii_txd, expw);
            end
        end
        @(negedge clk);
        expw = {8'hf0, 24'h070707, 8'hfd, fcs};
        checks++;
        if (bus.xgmii_txd !== expw) begin
            fails++;
            $display("FAIL %s term: txd=%h expected %h", tag, bus.xgmii_txd, expw);
        end
        m_frames++;
        m_id++;
        if (scramble) bus.payload_words = pw_save;
        checks++;
        if (bus.frame_count !== 32'(m_frames)) begin
            fails++;
            $display("FAIL %s frame_count: got %0d expected %0d", tag, bus.frame_count, m_frames);
        end
        checks++;
        if (bus.underrun_count !== 16'(m_under)) begin
            fails++;
            $display("FAIL %s underrun_count: got %0d expected %0d", tag, bus.underrun_count, m_under);
        end
        for (int g = 0; g < IFG; g++) begin
            @(negedge clk);
            checks++;
            if (bus.xgmii_txd !== IDLEW || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL %s gap%0d: txd=%h busy=%b expected %h busy=1", tag, g, bus.xgmii_txd, bus.busy, IDLEW);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.xgmii_txd !== IDLEW || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s post_gap_idle: txd=%h busy=%b expected %h busy=0", tag, bus.xgmii_txd, bus.busy, IDLEW);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        bus.tx_enable = 1'b0;
        bus.payload_words = 8'd2;
        rand_addr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.xgmii_txd !== IDLEW) begin fails++; $display("FAIL reset_txd: got %h expected %h", bus.xgmii_txd, IDLEW); end
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: rd_en=%b busy=%b expected 0 0", bus.fifo_rd_en, bus.busy);
        end
        checks++;
        if (bus.frame_count !== 32'd0 || bus.underrun_count !== 16'd0) begin
            fails++; $display("FAIL reset_counters: frames=%0d underruns=%0d expected 0 0", bus.frame_count, bus.underrun_count);
        end
        sys_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int r0;
        r0 = rd_pulses;
        rand_addr();
        bus.payload_words = 8'd2;
        bus.tx_enable = 1'b1;
        push_word(); push_word();
        check_frame("basic", 1'b0, 20);
        checks++;
        if (rd_pulses - r0 !== 2) begin fails++; $display("FAIL basic_rd_pulses: got %0d expected 2", rd_pulses - r0); end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rd_pulses;
        bus.payload_words = 8'd4;
        for (int i = 0; i < 12; i++) push_word();
        check_frame("b2b0", 1'b1, 20);
        check_frame("b2b1", 1'b1, 1);
        check_frame("b2b2", 1'b1, 1);
        checks++;
        if (rd_pulses - r0 !== 12) begin fails++; $display("FAIL b2b_rd_pulses: got %0d expected 12", rd_pulses - r0); end
    endtask

    task automatic test_underrun();
        int r0;
        r0 = rd_pulses;
        bus.payload_words = 8'd4;
        push_word(); push_word();
        check_frame("underrun", 1'b0, 20);
        checks++;
        if (bus.underrun_count !== 16'd2) begin fails++; $display("FAIL underrun_total: got %0d expected 2", bus.underrun_count); end
        checks++;
        if (rd_pulses - r0 !== 2) begin fails++; $display("FAIL underrun_rd_pulses: got %0d expected 2", rd_pulses - r0); end
    endtask

    task automatic test_clamp();
        bus.payload_words = 8'd0;
        push_word(); push_word();
        check_frame("clamp_low", 1'b0, 20);
        bus.payload_words = 8'd255;
        for (int i = 0; i < MAXW; i++) push_word();
        check_frame("clamp_high", 1'b0, 20);
    endtask

    task automatic test_enable_gate();
        int bad;
        bus.tx_enable = 1'b0;
        bus.payload_words = 8'd2;
        rand_addr();
        push_word(); push_word();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.xgmii_txd !== IDLEW || bus.fifo_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL gate_idle%0d: txd=%h rd_en=%b busy=%b expected %h 0 0", i, bus.xgmii_txd, bus.fifo_rd_en, bus.busy, IDLEW);
            end
        end
        bus.tx_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.xgmii_txd !== PRE) begin fails++; $display("FAIL gate_start: txd=%h expected %h", bus.xgmii_txd, PRE); end
        check_frame("gate_frame", 1'b0, 1);
    endtask

    task automatic test_mid_frame_reset();
        int waited;
        bus.payload_words = 8'd4;
        rand_addr();
        for (int i = 0; i < 4; i++) push_word();
        waited = 0;
        while (bus.xgmii_txd !== PRE && waited < 20) begin @(negedge clk); waited++; end
        checks++;
        if (bus.xgmii_txd !== PRE) begin
            fails++;
            $display("FAIL rst_preamble: txd=%h expected %h", bus.xgmii_txd, PRE);
        end
        repeat (8) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.xgmii_txd !== IDLEW || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_idle: txd=%h busy=%b rd_en=%b expected %h 0 0", bus.xgmii_txd, bus.busy, bus.fifo_rd_en, IDLEW);
        end
        checks++;
        if (bus.frame_count !== 32'd0 || bus.underrun_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid_counters: frames=%0d underruns=%0d expected 0 0", bus.frame_count, bus.underrun_count);
        end
        sys_rst = 1'b0;
        mq.delete();
        m_frames = 0;
        m_under = 0;
        m_id = 16'h0;
        @(negedge clk);
        checks++;
        if (bus.xgmii_txd !== IDLEW) begin fails++; $display("FAIL rst_no_term: txd=%h expected %h", bus.xgmii_txd, IDLEW); end
        bus.payload_words = 8'd2;
        push_word(); push_word();
        check_frame("after_reset", 1'b0, 20);
    endtask

    task automatic test_rd_rules();
        checks++;
        if (rd_viol !== 0) begin fails++; $display("FAIL rd_en_while_empty: got %0d expected 0", rd_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_clamp();
        test_enable_gate();
        test_mid_frame_reset();
        test_rd_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
